prbs_checker: RTL
=================

Name: prbs_checker

Overview:
- Parametrised-width, self-synchronising PRBS pattern checker, the receive-side partner of the PRBS generator family.
- Consumes one W-bit word per accepted beat and seeds its local LFSR from the incoming data.
- Tracks lock through a state machine and counts bit errors against the predicted sequence.
- Sits at the sink of loopback/link test paths; supports the same nine polynomial types as the generator.

Parameters:
W, 32, data word width in bits; legal range 32..128 (must cover the 31-bit PRBS31 seed).
LOCK_CNT, 4, consecutive error-free words required in LOCK_CHECK before asserting locked.
LOSS_CNT, 4, consecutive errored words in LOCKED that force resynchronisation.
ERR_W, 32, width of the saturating bit-error counter.

Ports:
clock  input  1  rising-edge clock; the only clock.
reset_n  input  1  asynchronous active-low reset.
type  input  4  polynomial select: 0=PRBS7 (x7+x6+1), 1=PRBS9 (x9+x5+1), 2=PRBS10 (x10+x7+1), 3=PRBS11 (x11+x9+1), 4=PRBS15 (x15+x14+1), 5=PRBS20 (x20+x3+1), 6=PRBS23 (x23+x18+1), 7=PRBS29 (x29+x27+1), 8=PRBS31 (x31+x28+1).
in_valid  input  1  in_data is valid this cycle.
in_data  input  W  received word; bit W-1 is the oldest bit, bit 0 the newest.
clear  input  1  synchronous clear of err_count and word_count; no effect on lock state.
locked  output  1  pattern lock status.
err_word  output  1  one-cycle pulse: the last accepted word mismatched while in LOCK_CHECK or LOCKED.
err_count  output  ERR_W  saturating count of mismatched bits while LOCKED.
word_count  output  32  words accepted while LOCKED; wraps modulo 2^32.
inverted  output  1  lock is to the inverted pattern (see Optional Feature).

Behaviour:
- Reset (reset_n=0, asynchronous): state=SEED; locked, err_word, inverted = 0; err_count, word_count = 0; LFSR state = 0.
- All processing occurs only on cycles with in_valid=1. With in_valid=0, all state holds and err_word=0.
- Prediction: from an n-bit state S, each step produces bit S[n-1]^S[k-1] and shifts it in at the LSB. Advancing W steps gives the expected next word, oldest bit first, mapped to bit W-1.
- Seeding: the LFSR state is loaded from in_data[n-1:0], where n is the polynomial degree.
- type is registered every cycle. Any change of the registered value, including a change mid-lock, forces state=SEED and locked=0 on the next cycle.
- Types 9..15 are unsupported. The block stays in SEED, never locks, and all counters hold.
- States:
  - SEED: on a valid word, seed the LFSR, clear the clean-word counter, and go to LOCK_CHECK.
  - LOCK_CHECK: on a valid word, compare against the prediction.
    - Match: increment the clean-word counter. On reaching LOCK_CNT, go to LOCKED and set locked=1 in the same registered update.
    - Mismatch: pulse err_word and go to SEED.
  - LOCKED: on a valid word, compare and increment word_count.
    - Mismatch: add popcount(in_data ^ expected) to err_count, saturating at 2^ERR_W-1; pulse err_word; increment the consecutive-bad counter.
    - Match: clear the consecutive-bad counter.
    - Bad counter reaching LOSS_CNT: go to SEED, set locked=0, keep err_count.
- The LFSR always advances from its own prediction, never from in_data, except when seeding.
- Latency: locked, err_word, err_count and word_count update on the clock edge after the accepted word, a registered 1-cycle latency.
- clear together with an errored word in the same cycle: clear wins, and the count becomes 0 (the error is not added).
- Saturation: err_count never wraps; a popcount addition that would overflow clamps to all-ones.

Optional Feature:
- Macro PRBS_INV_DETECT_EN.
- Defined:
  - In LOCK_CHECK, the checker compares in_data against both the prediction and its bitwise inverse.
  - The polarity that matches on the first word is latched into inverted. Later words must match that polarity.
  - In LOCKED, errors are counted against the latched polarity.
  - inverted clears on entry to SEED.
- Not defined:
  - inverted is tied to 0, and only true polarity locks.
  - An inverted stream never leaves the SEED/LOCK_CHECK loop.

Test Plan:
- W=32, type=0 (PRBS7), contiguous clean stream after reset release → locked=1 one cycle after the 5th accepted word (1 seed + 4 checks); err_count=0.
- Locked PRBS31, flip bit 5 of one word → err_word pulses once, err_count=1, locked stays 1; flip 3 bits in one word → err_count increases by 3.
- Locked PRBS15, 4 consecutive words replaced by 0x00000000 → locked=0 after the 4th; then clean data → relock after 5 words, with err_count preserved.
- in_valid deasserted for 10 cycles mid-lock, then the stream resumes → no errors, locked stays 1, word_count counts only valid beats.
- type switched 2→5 while locked → locked=0 next cycle; type=9 → never locks; reset_n pulsed low mid-LOCKED → all outputs 0 immediately, asynchronously.
- With PRBS_INV_DETECT_EN, an inverted PRBS23 stream → locked=1 and inverted=1; without the macro, the same stream → locked stays 0.

Source files
------------

// File: rtl/prbs_checker.sv
// -----------------------------------------------------------------------------
// prbs_checker
//
// Self-synchronising PRBS pattern checker. This is the receive-side partner of
// the PRBS generator family. It seeds a local LFSR from the incoming data, then
// predicts each following W-bit word. Lock status is tracked by a three-state
// FSM (SEED -> LOCK_CHECK -> LOCKED). While locked, the checker counts
// mismatched bits and accepted words.
//
// Supported polynomials (type_sel):
//   0=PRBS7  x7+x6+1     1=PRBS9  x9+x5+1     2=PRBS10 x10+x7+1
//   3=PRBS11 x11+x9+1    4=PRBS15 x15+x14+1   5=PRBS20 x20+x3+1
//   6=PRBS23 x23+x18+1   7=PRBS29 x29+x27+1   8=PRBS31 x31+x28+1
//   9..15 are unsupported. The checker parks in SEED and never locks.
//
// Optional feature, macro PRBS_INV_DETECT_EN:
//   When the macro is defined, the checker also locks to a bit-inverted stream
//   and reports that polarity on 'inverted'. When it is undefined, 'inverted'
//   stays 0 and only true polarity can lock.
//
// Ports:
//   clock       in   rising-edge clock
//   reset_n     in   asynchronous active-low reset
//   type_sel    in   [3:0] polynomial select (encoding above); registered each cycle
//   in_valid    in   in_data carries a word this cycle
//   in_data     in   [W-1:0] received word; bit W-1 oldest, bit 0 newest
//   clear       in   synchronous clear of err_count and word_count
//   locked      out  pattern lock status
//   err_word    out  one-cycle pulse: last accepted word mismatched (LOCK_CHECK/LOCKED)
//   err_count   out  [ERR_W-1:0] saturating count of mismatched bits while LOCKED
//   word_count  out  [31:0] words accepted while LOCKED, wraps
//   inverted    out  lock is to the inverted pattern
// -----------------------------------------------------------------------------
module prbs_checker #(
    parameter int W        = 32,  // 32..128, must hold the 31-bit PRBS31 seed
    parameter int LOCK_CNT = 4,   // clean words in LOCK_CHECK before locking
    parameter int LOSS_CNT = 4,   // consecutive bad words in LOCKED before resync
    parameter int ERR_W    = 32   // err_count width
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [3:0]       type_sel,
    input  logic             in_valid,
    input  logic [W-1:0]     in_data,
    input  logic             clear,
    output logic             locked,
    output logic             err_word,
    output logic [ERR_W-1:0] err_count,
    output logic [31:0]      word_count,
    output logic             inverted
);

    localparam int CLW  = $clog2(LOCK_CNT + 1);
    localparam int BLW  = $clog2(LOSS_CNT + 1);
    localparam int PCW  = $clog2(W + 1);
    localparam int SUMW = ERR_W + 1;

    typedef enum logic [1:0] {
        ST_SEED       = 2'd0,
        ST_LOCK_CHECK = 2'd1,
        ST_LOCKED     = 2'd2
    } state_t;

    // One prediction: the next W-bit word, and the LFSR state after W steps.
    typedef struct packed {
        logic [W-1:0] word;
        logic [30:0]  next;
    } pred_t;

    // Mask that keeps the low n bits, where tap_n = n-1 (n = polynomial degree).
    function automatic logic [30:0] deg_mask(input logic [4:0] tap_n);
        return 31'((32'h1 << (tap_n + 5'd1)) - 32'd1);
    endfunction

    // Run the LFSR W steps from 'seed'. Each step emits S[n-1]^S[k-1] and shifts
    // that bit in at the LSB. The first emitted bit is the oldest, so it lands
    // in bit W-1 of the word.
    function automatic pred_t predict(input logic [30:0] seed,
                                      input logic [4:0]  tap_n,
                                      input logic [4:0]  tap_k);
        logic [31:0] st;
        logic        fb;
        pred_t       r;
        st     = {1'b0, seed};
        r.word = '0;
        for (int i = 0; i < W; i++) begin
            fb            = st[tap_n] ^ st[tap_k];
            r.word[W-1-i] = fb;
            st            = {st[30:0], fb};
        end
        r.next = st[30:0] & deg_mask(tap_n);
        return r;
    endfunction

    function automatic logic [PCW-1:0] popcount(input logic [W-1:0] v);
        logic [PCW-1:0] c;
        c = '0;
        for (int i = 0; i < W; i++) begin
            c = c + PCW'(v[i]);
        end
        return c;
    endfunction

    // -------------------------------------------------------------------------
    // Registers and their next-state values
    // -------------------------------------------------------------------------
    state_t             state_q, state_d;
    logic [3:0]         type_q;
    logic [30:0]        lfsr_q, lfsr_d;
    logic [CLW-1:0]     clean_q, clean_d;
    logic [BLW-1:0]     bad_q, bad_d;
    logic               err_word_q, err_word_d;
    logic [ERR_W-1:0]   err_count_q, err_count_d;
    logic [31:0]        word_count_q, word_count_d;
    logic               inv_q, inv_d;

    // -------------------------------------------------------------------------
    // Polynomial decode from the registered type
    // -------------------------------------------------------------------------
    logic [4:0] tap_n;    // degree - 1
    logic [4:0] tap_k;    // inner tap - 1
    logic       type_ok;

    // NOTE: each combinational output gets a default first, so no path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        tap_n   = 5'd6;
        tap_k   = 5'd5;
        type_ok = 1'b1;
        case (type_q)
            4'd0:    begin tap_n = 5'd6;  tap_k = 5'd5;  end
            4'd1:    begin tap_n = 5'd8;  tap_k = 5'd4;  end
            4'd2:    begin tap_n = 5'd9;  tap_k = 5'd6;  end
            4'd3:    begin tap_n = 5'd10; tap_k = 5'd8;  end
            4'd4:    begin tap_n = 5'd14; tap_k = 5'd13; end
            4'd5:    begin tap_n = 5'd19; tap_k = 5'd2;  end
            4'd6:    begin tap_n = 5'd22; tap_k = 5'd17; end
            4'd7:    begin tap_n = 5'd28; tap_k = 5'd26; end
            4'd8:    begin tap_n = 5'd30; tap_k = 5'd27; end
            default: type_ok = 1'b0;
        endcase
    end

    // A new type value resynchronises the checker. The word presented in the
    // same cycle is dropped, because it belongs to the old pattern.
    logic type_chg;
    logic accept;
    assign type_chg = (type_sel != type_q);
    assign accept   = in_valid && !type_chg;

    // -------------------------------------------------------------------------
    // Prediction and comparison
    // -------------------------------------------------------------------------
    pred_t pred_true;
    assign pred_true = predict(lfsr_q, tap_n, tap_k);

`ifdef PRBS_INV_DETECT_EN
    // The LFSR recurrence has an even number of taps, so an inverted seed does
    // not yield an inverted sequence. Undoing the inversion on the seed and
    // re-running gives the true-polarity word that an inverted stream follows.
    pred_t pred_alt;
    assign pred_alt = predict(lfsr_q ^ deg_mask(tap_n), tap_n, tap_k);
`endif

    logic [W-1:0]   expect_word;
    logic [30:0]    adv_next;     // true-polarity LFSR state after this word
    logic           pol;          // polarity to latch if this word is clean
    logic [W-1:0]   diff;
    logic           mismatch;
    logic [PCW-1:0] pop;
    logic [SUMW-1:0] err_sum;
    logic [ERR_W-1:0] err_sat;

    always_comb begin
        expect_word = pred_true.word;
        adv_next    = pred_true.next;
        pol         = inv_q;
`ifdef PRBS_INV_DETECT_EN
        if (state_q == ST_LOCK_CHECK && clean_q == '0) begin
            // The first word after seeding decides polarity. True polarity
            // takes priority when both candidates would match.
            pol = 1'b0;
            if (in_data != pred_true.word && in_data == ~pred_alt.word) begin
                expect_word = ~pred_alt.word;
                adv_next    = pred_alt.next;
                pol         = 1'b1;
            end
        end else begin
            expect_word = pred_true.word ^ {W{inv_q}};
        end
`else
        pol = 1'b0;
`endif
    end

    assign diff     = in_data ^ expect_word;
    assign mismatch = |diff;
    assign pop      = popcount(diff);
    assign err_sum  = {1'b0, err_count_q} + SUMW'(pop);
    // A carry out of the top bit means the addition overflowed, so clamp.
    assign err_sat  = err_sum[ERR_W] ? {ERR_W{1'b1}} : err_sum[ERR_W-1:0];

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking assignments, so every register samples pre-edge values regardless of block order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_SEED;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (type_chg) begin
            state_d = ST_SEED;
        end else if (in_valid) begin
            case (state_q)
                ST_SEED: begin
                    if (type_ok) state_d = ST_LOCK_CHECK;
                end
                ST_LOCK_CHECK: begin
                    if (mismatch)
                        state_d = ST_SEED;
                    else if (clean_q == CLW'(LOCK_CNT - 1))
                        state_d = ST_LOCKED;
                end
                ST_LOCKED: begin
                    if (mismatch && bad_q == BLW'(LOSS_CNT - 1))
                        state_d = ST_SEED;
                end
                default: state_d = ST_SEED;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // FSM: output / datapath next values
    // -------------------------------------------------------------------------
    always_comb begin
        lfsr_d       = lfsr_q;
        clean_d      = clean_q;
        bad_d        = bad_q;
        err_word_d   = 1'b0;
        err_count_d  = err_count_q;
        word_count_d = word_count_q;
        inv_d        = inv_q;

        if (accept) begin
            case (state_q)
                ST_SEED: begin
                    if (type_ok) begin
                        lfsr_d  = in_data[30:0] & deg_mask(tap_n);
                        clean_d = '0;
                        bad_d   = '0;
                    end
                end
                ST_LOCK_CHECK: begin
                    // The LFSR advances from its own prediction, not from in_data.
                    lfsr_d = adv_next;
                    if (mismatch) begin
                        err_word_d = 1'b1;
                    end else begin
                        clean_d = clean_q + CLW'(1);
                        bad_d   = '0;
                        inv_d   = pol;
                    end
                end
                ST_LOCKED: begin
                    lfsr_d       = adv_next;
                    word_count_d = word_count_q + 32'd1;
                    if (mismatch) begin
                        err_word_d  = 1'b1;
                        err_count_d = err_sat;
                        bad_d       = bad_q + BLW'(1);
                    end else begin
                        bad_d = '0;
                    end
                end
                default: ;
            endcase
        end

        // Polarity is forgotten whenever the checker (re)enters SEED.
        if (state_d == ST_SEED) inv_d = 1'b0;

        // Clear has priority over any increment in the same cycle.
        if (clear) begin
            err_count_d  = '0;
            word_count_d = '0;
        end
    end

    always_comb begin
        locked     = (state_q == ST_LOCKED);
        err_word   = err_word_q;
        err_count  = err_count_q;
        word_count = word_count_q;
        inverted   = inv_q;
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            type_q       <= 4'd0;
            lfsr_q       <= '0;
            clean_q      <= '0;
            bad_q        <= '0;
            err_word_q   <= 1'b0;
            err_count_q  <= '0;
            word_count_q <= '0;
            inv_q        <= 1'b0;
        end else begin
            type_q       <= type_sel;
            lfsr_q       <= lfsr_d;
            clean_q      <= clean_d;
            bad_q        <= bad_d;
            err_word_q   <= err_word_d;
            err_count_q  <= err_count_d;
            word_count_q <= word_count_d;
            inv_q        <= inv_d;
        end
    end

endmodule
